// File: rtl/ps_bigreg_ctrl_pkg.sv
// Shared types for the PS big-register controllers: write response codes,
// the output-side state encoding and per-instance big-register descriptors.
package ps_bigreg_ctrl_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // Output register occupancy; the armed flag is kept separately.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [7:0] base_id;
    logic [7:0] samples;
    logic       partial_ok;
  } bigreg_desc_t;

  // Existing big registers in the mem map.
  localparam bigreg_desc_t SEED_DESC     = '{base_id: 8'd1,  samples: 8'd16, partial_ok: 1'b0};
  localparam bigreg_desc_t CHAN_MUX_DESC = '{base_id: 8'd18, samples: 8'd8,  partial_ok: 1'b0};
  localparam bigreg_desc_t SDC_DESC      = '{base_id: 8'd27, samples: 8'd4,  partial_ok: 1'b1};

  // Width of a word index; never zero, even for a single-word register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps_bigreg_ctrl_if.sv
// Mem-map write path plus the big-register delivery channel.
//
// Delivery handshake: a value transfers on every rising clk edge where
// bigreg_valid=1 and bigreg_ready=1. While bigreg_valid=1 and bigreg_ready=0
// bigreg_data holds. bigreg_valid never waits on bigreg_ready to assert.
interface ps_bigreg_ctrl_if #(
  parameter int ID_W    = 8,
  parameter int WORD_W  = 16,
  parameter int SAMPLES = 16
);
  logic                      wr_en;
  logic [ID_W-1:0]           wr_id;
  logic [WORD_W-1:0]         wr_data;
  logic                      wr_resp_valid;
  logic [1:0]                wr_resp;
  logic [SAMPLES*WORD_W-1:0] bigreg_data;
  logic                      bigreg_valid;
  logic                      bigreg_ready;
  logic [SAMPLES-1:0]        fresh_mask;
  logic                      armed;
  logic                      clr_fresh;

  modport master (
    output wr_en, wr_id, wr_data, bigreg_ready,
    input  wr_resp_valid, wr_resp, bigreg_data, bigreg_valid,
           fresh_mask, armed, clr_fresh
  );

  modport slave (
    input  wr_en, wr_id, wr_data, bigreg_ready,
    output wr_resp_valid, wr_resp, bigreg_data, bigreg_valid,
           fresh_mask, armed, clr_fresh
  );
endinterface

// File: rtl/ps_bigreg_ctrl_bigreg_assembler.sv
// Assembly buffer for one big register: holds the latest value of every
// word and which words were written since the last commit. The buffer is
// never cleared by a commit so unwritten words keep their previous value.
module bigreg_assembler #(
  parameter int W       = 16,
  parameter int SAMPLES = 16,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [W-1:0]         i_data,
  input  logic                 i_clr,
  output logic [SAMPLES*W-1:0] o_asm,
  output logic [SAMPLES-1:0]   o_fresh,
  output logic                 o_complete
);
  logic [SAMPLES*W-1:0] r_asm;
  logic [SAMPLES-1:0]   r_fresh;

  // Store accepted word writes and track freshness; a commit clears freshness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm   <= '0;
      r_fresh <= '0;
    end else begin
      for (int i = 0; i < SAMPLES; i++) begin
        if (i_wr && (i_idx == IDX_W'(i))) begin
          r_asm[i*W +: W] <= i_data;
          r_fresh[i]      <= 1'b1;
        end
      end
      if (i_clr) r_fresh <= '0;
    end
  end

  assign o_asm      = r_asm;
  assign o_fresh    = r_fresh;
  assign o_complete = &r_fresh;
endmodule

// File: rtl/ps_bigreg_ctrl.sv
// PS big-register controller: decodes mem-map writes into word writes and
// commit requests, answers each in-range write, and delivers committed
// values through a one-deep commit queue (the armed flag).
module ps_bigreg_ctrl
  import ps_bigreg_ctrl_pkg::*;
#(
  parameter int MEM_SIZE      = 256,
  parameter int WD_DATA_WIDTH = 16,
  parameter int BASE_ID       = 1,
  parameter int SAMPLES       = 16,
  parameter int PARTIAL_OK    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ps_bigreg_ctrl_if.slave       bus,
  output out_state_e            o_state
);
  localparam int ID_W  = $clog2(MEM_SIZE);
  localparam int IDX_W = idx_width(SAMPLES);
  localparam int DW    = SAMPLES * WD_DATA_WIDTH;
  localparam logic [ID_W-1:0] L_BASE  = ID_W'(BASE_ID);
  localparam logic [ID_W-1:0] L_VALID = ID_W'(BASE_ID + SAMPLES);

  out_state_e         r_state;
  logic               r_armed;
  logic [DW-1:0]      r_data;
  logic               r_resp_valid;
  resp_e              r_resp;
  logic               r_clr_fresh;

  logic               w_word_hit;
  logic               w_valid_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [DW-1:0]      w_asm;
  logic [SAMPLES-1:0] w_fresh;
  logic               w_complete;
  logic               w_out_free;
  logic               w_commit_ok;
  logic               w_load;
  logic               w_slverr;

  assign w_word_hit  = bus.wr_en && (bus.wr_id >= L_BASE) && (bus.wr_id < L_VALID);
  assign w_valid_hit = bus.wr_en && (bus.wr_id == L_VALID);
  assign w_idx       = IDX_W'(bus.wr_id - L_BASE);
  // Accept and refill in the same cycle is allowed, so ready frees the slot.
  assign w_out_free  = (r_state == OUT_EMPTY) || bus.bigreg_ready;
  assign w_commit_ok = w_valid_hit && !r_armed && (w_complete || (PARTIAL_OK != 0));
  // Either a direct commit or the queued (armed) commit moves into the output.
  assign w_load      = w_out_free && (w_commit_ok || r_armed);
  assign w_slverr    = (w_word_hit && r_armed) || (w_valid_hit && !w_commit_ok);

  bigreg_assembler #(
    .W       (WD_DATA_WIDTH),
    .SAMPLES (SAMPLES),
    .IDX_W   (IDX_W)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr       (w_word_hit && !r_armed),
    .i_idx      (w_idx),
    .i_data     (bus.wr_data),
    .i_clr      (w_load),
    .o_asm      (w_asm),
    .o_fresh    (w_fresh),
    .o_complete (w_complete)
  );

  // Output-side state machine with the armed flag, responses and clr pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= OUT_EMPTY;
      r_armed      <= 1'b0;
      r_data       <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= RESP_OKAY;
      r_clr_fresh  <= 1'b0;
    end else begin
      r_resp_valid <= w_word_hit || w_valid_hit;
      r_resp       <= w_slverr ? RESP_SLVERR : RESP_OKAY;
      r_clr_fresh  <= w_load;

      case (r_state)
        OUT_EMPTY: if (w_load) r_state <= OUT_FULL;
        OUT_FULL:  if (bus.bigreg_ready && !w_load) r_state <= OUT_EMPTY;
        default:   r_state <= OUT_EMPTY;
      endcase
      if (w_load) r_data <= w_asm;

      if (w_commit_ok && !w_out_free) r_armed <= 1'b1;
      else if (r_armed && w_out_free) r_armed <= 1'b0;
    end
  end

  assign bus.wr_resp_valid = r_resp_valid;
  assign bus.wr_resp       = r_resp;
  assign bus.bigreg_data   = r_data;
  assign bus.bigreg_valid  = (r_state == OUT_FULL);
  assign bus.fresh_mask    = w_fresh;
  assign bus.armed         = r_armed;
  assign bus.clr_fresh     = r_clr_fresh;
  assign o_state           = r_state;
endmodule
